// File: rtl/video_types.sv
// Shared video-subsystem definitions: OAM placement/size and the OAM DMA state encoding.
package video_types;

  localparam logic [15:0] OAM_LOC  = 16'hFE00;
  localparam int unsigned OAM_SIZE = 160;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE
  } dma_state_t;

  // The CPU is locked out of OAM only while bytes are actually moving.
  function automatic logic dma_busy(input dma_state_t s);
    return (s == READ) || (s == WAIT) || (s == WRITE);
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies OAM_LEN bytes from {src_hi, 8'h00} into OAM, one read/write pair per byte.
module oam_dma
  import video_types::*;
#(
  parameter logic [15:0] DMA_REG_ADDR   = 16'hFF46,
  parameter logic [15:0] OAM_BASE       = OAM_LOC,
  parameter int unsigned OAM_LEN        = OAM_SIZE,
  parameter int unsigned RVALID_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  reg_rdata,
  output logic        reg_rd_valid,
  output logic [15:0] m_addr,
  output logic        m_rd,
  output logic        m_wr,
  output logic [7:0]  m_wdata,
  input  logic [7:0]  m_rdata,
  input  logic        m_rvalid,
  output logic        busy,
  output logic        done
);

  dma_state_t state_q, state_d;

  logic [7:0] src_hi;
  logic [7:0] idx;
  logic [7:0] data_q;
  logic [7:0] wait_cnt;

  logic reg_hit_wr;
  logic reg_hit_rd;
  logic last_byte;
  logic wait_expired;

  assign reg_hit_wr   = cpu_wr && (cpu_addr == DMA_REG_ADDR);
  assign reg_hit_rd   = cpu_rd && (cpu_addr == DMA_REG_ADDR);
  assign last_byte    = (idx == 8'(OAM_LEN - 1));
  assign wait_expired = (wait_cnt == 8'(RVALID_TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A register write restarts from any state, aborting whatever byte is in flight.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves a signal unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = IDLE;
      READ:    state_d = WAIT;
      WAIT:    if (m_rvalid || wait_expired) state_d = WRITE;
      WRITE:   state_d = last_byte ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (reg_hit_wr) state_d = READ;
  end

  always_comb begin
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    m_addr  = 16'h0000;
    m_wdata = 8'h00;
    busy    = dma_busy(state_q);
    done    = (state_q == DONE);
    unique case (state_q)
      READ: begin
        m_rd   = 1'b1;
        m_addr = {src_hi, idx};
      end
      WRITE: begin
        m_wr    = 1'b1;
        m_addr  = OAM_BASE + {8'h00, idx};
        m_wdata = data_q;
      end
      default: ;
    endcase
  end

  // Datapath: source page, byte index, captured read data and read-wait counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      src_hi   <= 8'h00;
      idx      <= 8'h00;
      data_q   <= 8'h00;
      wait_cnt <= 8'h00;
    end else begin
      if (reg_hit_wr) begin
        src_hi <= cpu_wdata;
        idx    <= 8'h00;
      end else if ((state_q == WRITE) && !last_byte) begin
        idx <= idx + 8'd1;
      end

      if (state_q == READ) begin
        wait_cnt <= 8'h00;
      end else if (state_q == WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      // Read data is only believed while waiting for it; a silent bus yields 8'hFF.
      if (state_q == WAIT) begin
        if (m_rvalid) begin
          data_q <= m_rdata;
        end else if (wait_expired) begin
          data_q <= 8'hFF;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      reg_rd_valid <= 1'b0;
      reg_rdata    <= 8'h00;
    end else begin
      reg_rd_valid <= reg_hit_rd;
      reg_rdata    <= reg_hit_rd ? src_hi : 8'h00;
    end
  end

endmodule
